// File: rtl/rtc_arbiter.sv
// rtc_arbiter: round-robin arbiter/sequencer sharing one RTC among NREQ
// requesters. Each grant issues a one-cycle rtc_on, waits RD_LAT cycles,
// captures r_data and returns it with a one-cycle done pulse.
// Build macro RTC_ARB_ALARM_LATCH_EN: alarm_irq becomes a sticky,
// rising-edge-set interrupt cleared by alarm_clr; otherwise alarm_irq is
// simply alarm delayed by one flop.
module rtc_arbiter #(
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 arb_en,
    input  logic [NREQ-1:0]                      req,
    input  logic [2*NREQ-1:0]                    req_op,
    input  logic [32*NREQ-1:0]                   req_wdata,
    output logic [NREQ-1:0]                      done,
    output logic [31:0]                          rdata,
    output logic                                 busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_id,
    output logic                                 rtc_on,
    output logic [1:0]                           operation,
    output logic [31:0]                          w_data,
    input  logic [31:0]                          r_data,
    input  logic                                 alarm,
    input  logic                                 alarm_clr,
    output logic                                 alarm_irq
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0]      LAT_LOAD = 3'(RD_LAT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]    state;
    logic [IW-1:0] last;
    logic [2:0]    cnt;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          any_req;

    // Round-robin pick: first active request after the previous winner, wrapping
    always_comb begin
        winner  = last;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    // Transaction sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last      <= IW'(NREQ - 1);
            gnt_id    <= '0;
            cnt       <= '0;
            rtc_on    <= 1'b0;
            busy      <= 1'b0;
            done      <= '0;
            operation <= 2'b00;
            w_data    <= '0;
            rdata     <= '0;
        end else begin
            rtc_on <= 1'b0;
            done   <= '0;
            case (state)
                IDLE: begin
                    // Operands are sampled only here; later changes are ignored.
                    if (arb_en && any_req) begin
                        gnt_id    <= winner;
                        last      <= winner;
                        operation <= req_op[{winner, 1'b0} +: 2];
                        w_data    <= req_wdata[{winner, 5'd0} +: 32];
                        rtc_on    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= LAT_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    // r_data is captured for every op, not only reads.
                    if (cnt == 3'd0) begin
                        rdata <= r_data;
                        done  <= ONE_HOT0 << gnt_id;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RTC_ARB_ALARM_LATCH_EN
    logic alarm_prev;

    // Sticky interrupt set on alarm rising edge; set beats a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alarm_prev <= 1'b0;
            alarm_irq  <= 1'b0;
        end else begin
            alarm_prev <= alarm;
            if (alarm && !alarm_prev) begin
                alarm_irq <= 1'b1;
            end else if (alarm_clr) begin
                alarm_irq <= 1'b0;
            end
        end
    end
`else
    logic unused_alarm_clr;
    assign unused_alarm_clr = alarm_clr;

    // Interrupt is the alarm level delayed by one flop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alarm_irq <= 1'b0;
        end else begin
            alarm_irq <= alarm;
        end
    end
`endif

endmodule

// File: tb/tb_rtc_arbiter.sv
// Scoreboard bench for rtc_arbiter: stimulus pushes expected issue and
// completion records; a negedge monitor pops and compares them whenever
// the DUT shows rtc_on or done. A second instance with RD_LAT=4 covers
// reset in the middle of WAIT.
module tb_rtc_arbiter;

    localparam int NREQ    = 4;
    localparam int RD_LAT  = 1;
    localparam int RD_LAT4 = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           arb_en = 1'b0;
    logic [3:0]     req = '0;
    logic [7:0]     req_op = '0;
    logic [127:0]   req_wdata = '0;
    logic [31:0]    r_data = '0;
    logic           alarm = 1'b0;
    logic           alarm_clr = 1'b0;

    logic [3:0]     done;
    logic [31:0]    rdata;
    logic           busy;
    logic [1:0]     gnt_id;
    logic           rtc_on;
    logic [1:0]     operation;
    logic [31:0]    w_data;
    logic           alarm_irq;

    logic           resetn4 = 1'b0;
    logic           arb_en4 = 1'b0;
    logic [3:0]     req4 = '0;
    logic [3:0]     done4;
    logic [31:0]    rdata4;
    logic           busy4;
    logic [1:0]     gnt4;
    logic           rtc_on4;
    logic [1:0]     operation4;
    logic [31:0]    w_data4;
    logic           alarm_irq4;

    rtc_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .resetn(resetn), .arb_en(arb_en), .req(req),
        .req_op(req_op), .req_wdata(req_wdata), .done(done), .rdata(rdata),
        .busy(busy), .gnt_id(gnt_id), .rtc_on(rtc_on), .operation(operation),
        .w_data(w_data), .r_data(r_data), .alarm(alarm),
        .alarm_clr(alarm_clr), .alarm_irq(alarm_irq)
    );

    rtc_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT4)) dut4 (
        .clk(clk), .resetn(resetn4), .arb_en(arb_en4), .req(req4),
        .req_op(req_op), .req_wdata(req_wdata), .done(done4), .rdata(rdata4),
        .busy(busy4), .gnt_id(gnt4), .rtc_on(rtc_on4), .operation(operation4),
        .w_data(w_data4), .r_data(r_data), .alarm(alarm),
        .alarm_clr(alarm_clr), .alarm_irq(alarm_irq4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [1:0]  gnt;
    } iss_t;

    typedef struct {
        logic [3:0]  dn;
        logic [31:0] rd;
        logic [1:0]  gnt;
    } resp_t;

    iss_t  iss_q[$];
    resp_t resp_q[$];
    iss_t  ei;
    resp_t er;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [31:0] rd);
        iss_t  a;
        resp_t b;
        a.op    = req_op[2*g +: 2];
        a.wdata = req_wdata[32*g +: 32];
        a.gnt   = g;
        b.dn    = 4'b0001 << g;
        b.rd    = rd;
        b.gnt   = g;
        iss_q.push_back(a);
        resp_q.push_back(b);
    endtask

    // Monitor: compare every rtc_on and done against the scoreboard queues
    always @(negedge clk) begin
        if (resetn) begin
            if (rtc_on) begin
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", 32'd1, 32'd0);
                end else begin
                    ei = iss_q.pop_front();
                    check("issue_op", {30'd0, operation}, {30'd0, ei.op});
                    check("issue_wdata", w_data, ei.wdata);
                    check("issue_gnt", {30'd0, gnt_id}, {30'd0, ei.gnt});
                end
            end
            if (done != 4'b0) begin
                if (resp_q.size() == 0) begin
                    check("done_unexpected", {28'd0, done}, 32'd0);
                end else begin
                    er = resp_q.pop_front();
                    check("done_vec", {28'd0, done}, {28'd0, er.dn});
                    check("done_rdata", rdata, er.rd);
                    check("done_gnt", {30'd0, gnt_id}, {30'd0, er.gnt});
                end
            end
        end
    end

    initial begin
        bit ok;
        int prev;
        int lat;
        logic [31:0] w1;

        // Reset values
        #2;
        check("rst_rtc_on", {31'd0, rtc_on}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_irq", {31'd0, alarm_irq}, 32'd0);
        check("rst_op", {30'd0, operation}, 32'd0);
        check("rst_wdata", w_data, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_gnt", {30'd0, gnt_id}, 32'd0);
        tick();
        tick();
        resetn  = 1'b1;
        resetn4 = 1'b1;
        tick();

        // Fairness: all four requesting, 8 read transactions
        for (int i = 0; i < 4; i++) req_wdata[32*i +: 32] = 32'hC0DE_0000 | i;
        req_op = 8'h00;
        r_data = 32'hA5A5_0000;
        for (int n = 0; n < 8; n++) push(2'(n % 4), 32'hA5A5_0000);
        arb_en = 1'b1;
        req    = 4'hF;
        prev   = 0;
        for (int n = 0; n < 8; n++) begin
            wait_done(ok);
            if (!ok) begin
                check("fair_timeout", 32'd0, 32'd1);
                break;
            end
            if (n > 0) check("fair_spacing", 32'(cyc - prev), 32'(3 + RD_LAT));
            prev = cyc;
            if (n == 7) req = 4'h0;
        end
        tick();

        // Reset, then single write from requester 0
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        w1 = {6'd1, 6'd1, 5'd1, 9'd1, 6'd1};
        req_op[1:0]      = 2'b01;
        req_wdata[31:0]  = w1;
        r_data           = 32'h1111_2222;
        push(2'd0, 32'h1111_2222);
        req[0] = 1'b1;
        check("wr_busy_c0", {31'd0, busy}, 32'd0);
        tick();
        check("wr_rtc_on_c1", {31'd0, rtc_on}, 32'd1);
        check("wr_op_c1", {30'd0, operation}, 32'd1);
        check("wr_wdata_c1", w_data, 32'h0410_8041);
        check("wr_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check("wr_rtc_on_c2", {31'd0, rtc_on}, 32'd0);
        check("wr_wdata_hold_c2", w_data, 32'h0410_8041);
        tick();
        check("wr_done_c3", {28'd0, done}, 32'd1);
        req[0] = 1'b0;
        tick();
        check("wr_busy_c4", {31'd0, busy}, 32'd0);
        check("wr_no_done_c4", {28'd0, done}, 32'd0);

        // Read from requester 2 with RTC returning 0xDEADBEEF
        r_data = 32'hDEAD_BEEF;
        push(2'd2, 32'hDEAD_BEEF);
        req[2] = 1'b1;
        wait_done(ok);
        if (!ok) check("rd2_timeout", 32'd0, 32'd1);
        check("rd2_rdata_at_done", rdata, 32'hDEAD_BEEF);
        req[2] = 1'b0;
        r_data = 32'h0;
        tick();
        tick();
        tick();
        check("rd2_rdata_hold", rdata, 32'hDEAD_BEEF);

        // arb_en low blocks new grants
        arb_en = 1'b0;
        req_op[3:2]     = 2'b11;
        req_wdata[63:32] = 32'h0000_0F0F;
        r_data          = 32'h1357_2468;
        req[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("dis_rtc_on", {31'd0, rtc_on}, 32'd0);
            check("dis_busy", {31'd0, busy}, 32'd0);
        end
        push(2'd1, 32'h1357_2468);
        arb_en = 1'b1;
        tick();
        check("en_rtc_on_next", {31'd0, rtc_on}, 32'd1);
        wait_done(ok);
        if (!ok) check("en_timeout", 32'd0, 32'd1);
        req[1] = 1'b0;
        tick();

        // Reset in the middle of WAIT on the RD_LAT=4 instance
        req_op[7:6]        = 2'b10;
        req_wdata[127:96]  = 32'h7777_0003;
        req4    = 4'b1000;
        arb_en4 = 1'b1;
        tick();
        check("l4_rtc_on_c1", {31'd0, rtc_on4}, 32'd1);
        check("l4_gnt_c1", {30'd0, gnt4}, 32'd3);
        check("l4_op_c1", {30'd0, operation4}, 32'd2);
        tick();
        tick();
        check("l4_busy_c3", {31'd0, busy4}, 32'd1);
        check("l4_rtc_on_c3", {31'd0, rtc_on4}, 32'd0);
        resetn4 = 1'b0;
        #1;
        check("l4_rst_busy", {31'd0, busy4}, 32'd0);
        check("l4_rst_gnt", {30'd0, gnt4}, 32'd0);
        check("l4_rst_op", {30'd0, operation4}, 32'd0);
        check("l4_rst_wdata", w_data4, 32'd0);
        check("l4_rst_done", {28'd0, done4}, 32'd0);
        req4 = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("l4_no_done_in_rst", {28'd0, done4}, 32'd0);
        end
        resetn4 = 1'b1;
        tick();
        check("l4_regrant_rtc_on", {31'd0, rtc_on4}, 32'd1);
        check("l4_regrant_gnt0", {30'd0, gnt4}, 32'd0);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            lat++;
            if (done4 != 4'b0) break;
        end
        check("l4_done_vec", {28'd0, done4}, 32'd1);
        check("l4_done_latency", 32'(lat), 32'(1 + RD_LAT4));
        req4 = 4'b0000;
        tick();

        // Alarm conditioning
        alarm = 1'b1;
        tick();
        check("irq_after_alarm", {31'd0, alarm_irq}, 32'd1);
        alarm = 1'b0;
        tick();
`ifdef RTC_ARB_ALARM_LATCH_EN
        check("irq_sticky", {31'd0, alarm_irq}, 32'd1);
        tick();
        check("irq_sticky2", {31'd0, alarm_irq}, 32'd1);
        alarm_clr = 1'b1;
        tick();
        check("irq_cleared", {31'd0, alarm_irq}, 32'd0);
        alarm_clr = 1'b0;
`else
        check("irq_follows_low", {31'd0, alarm_irq}, 32'd0);
        alarm_clr = 1'b1;
        alarm     = 1'b1;
        tick();
        check("irq_ignores_clr", {31'd0, alarm_irq}, 32'd1);
        alarm_clr = 1'b0;
        alarm     = 1'b0;
        tick();
        check("irq_follows_low2", {31'd0, alarm_irq}, 32'd0);
`endif
        tick();
        check("iss_q_empty", 32'(iss_q.size()), 32'd0);
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
